// File: rtl/datapath.sv
// ---------------------------------------------------------------------------
// datapath
//
// Purpose:
//   A 32 x 32-bit register bank feeding a small combinational ALU. Two
//   registers are read asynchronously as operands A (rs_1) and B (rs_2).
//   The selected operation's result is presented on alu_result in the same
//   cycle. A single write port updates one register per rising clock edge.
//
// Ports:
//   clk          in   1   sole clock, all state updates on the rising edge
//   rst_n        in   1   asynchronous active-low reset, clears X1..X31
//   write_rb     in   1   register-bank write enable
//   rd_0         in   5   destination register index for writes
//   writedata    in  32   data written to X[rd_0]
//   rs_1         in   5   read-port-1 index (ALU operand A)
//   rs_2         in   5   read-port-2 index (ALU operand B)
//   alu_control  in   3   ALU operation select
//   alu_result   out 32   combinational ALU result
//
// ALU operation codes:
//   000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT (optional), others -> 0.
//   ADD and SUB wrap modulo 2^32; there is no carry or overflow output.
//
// Configuration:
//   DATAPATH_SLT_EN  when defined, code 111 yields the signed set-less-than
//                    result (1 if signed A < signed B, else 0). When the
//                    macro is undefined, code 111 yields 0.
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// register_bank
//
// Purpose:
//   32 x 32-bit registers X0..X31 with two combinational read ports and one
//   synchronous write port. X0 is hard-wired to zero.
//
// Ports:
//   clk, rst_n    clock and asynchronous active-low reset
//   write_rb      write enable, sampled on the rising clock edge
//   rd_0          write index
//   writedata     write data
//   rs_1, rs_2    read indices
//   readdata_1/2  read data, no clock latency
// ---------------------------------------------------------------------------
module register_bank (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        write_rb,
    input  logic [4:0]  rd_0,
    input  logic [31:0] writedata,
    input  logic [4:0]  rs_1,
    input  logic [4:0]  rs_2,
    output logic [31:0] readdata_1,
    output logic [31:0] readdata_2
);

    // Entry 0 is never written and stays at its reset value; reads of index
    // 0 are also forced to zero so X0 is zero even before the first reset.
    logic [31:0] regs [32];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'd0;
            end
        end else if (write_rb && (rd_0 != 5'd0)) begin
            regs[rd_0] <= writedata;
        end
    end

    // Reads come straight from the storage array. A read of the register
    // being written returns the old value until the edge: no bypass path.
    always_comb begin
        readdata_1 = 32'd0;
        if (rs_1 != 5'd0) begin
            readdata_1 = regs[rs_1];
        end
    end

    always_comb begin
        readdata_2 = 32'd0;
        if (rs_2 != 5'd0) begin
            readdata_2 = regs[rs_2];
        end
    end

endmodule

// ---------------------------------------------------------------------------
// alu
//
// Purpose:
//   Purely combinational 32-bit ALU.
//
// Ports:
//   a, b         operands
//   alu_control  operation select (see datapath header)
//   result       operation result
// ---------------------------------------------------------------------------
module alu (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  alu_control,
    output logic [31:0] result
);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    logic [31:0] sum;
    logic [31:0] diff;
    logic        less_signed;

    // Truncating to 32 bits gives the modulo-2^32 wrap.
    assign sum         = a + b;
    assign diff        = a - b;
    assign less_signed = $signed(a) < $signed(b);

    always_comb begin
        result = 32'd0;
        case (alu_control)
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_ADD:  result = sum;
            OP_SUB:  result = diff;
`ifdef DATAPATH_SLT_EN
            OP_SLT:  result = {31'd0, less_signed};
`else
            OP_SLT:  result = 32'd0;
`endif
            default: result = 32'd0;
        endcase
    end

endmodule

module datapath (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        write_rb,
    input  logic [4:0]  rd_0,
    input  logic [31:0] writedata,
    input  logic [4:0]  rs_1,
    input  logic [4:0]  rs_2,
    input  logic [2:0]  alu_control,
    output logic [31:0] alu_result
);

    logic [31:0] readdata_1;
    logic [31:0] readdata_2;

    register_bank REGISTER_BANK (
        .clk        (clk),
        .rst_n      (rst_n),
        .write_rb   (write_rb),
        .rd_0       (rd_0),
        .writedata  (writedata),
        .rs_1       (rs_1),
        .rs_2       (rs_2),
        .readdata_1 (readdata_1),
        .readdata_2 (readdata_2)
    );

    alu ALU (
        .a           (readdata_1),
        .b           (readdata_2),
        .alu_control (alu_control),
        .result      (alu_result)
    );

endmodule

// File: tb/tb_datapath.sv
// ---------------------------------------------------------------------------
// tb_datapath
//
// Directed bench for datapath. Inputs change half a cycle away from the
// rising edge. Outputs are sampled 1 time unit after a change or an edge.
// Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_datapath;

    logic        clk;
    logic        rst_n;
    logic        write_rb;
    logic [4:0]  rd_0;
    logic [31:0] writedata;
    logic [4:0]  rs_1;
    logic [4:0]  rs_2;
    logic [2:0]  alu_control;
    logic [31:0] alu_result;

    int checks_n;
    int fails_n;
    logic [31:0] exp_slt;

    datapath dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .write_rb    (write_rb),
        .rd_0        (rd_0),
        .writedata   (writedata),
        .rs_1        (rs_1),
        .rs_2        (rs_2),
        .alu_control (alu_control),
        .alu_result  (alu_result)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_n++;
        assert (obs === exp) else begin
            fails_n++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic alu_check(input string tag, input logic [4:0] a_idx, input logic [4:0] b_idx,
                             input logic [2:0] op, input logic [31:0] exp);
        @(negedge clk);
        rs_1        = a_idx;
        rs_2        = b_idx;
        alu_control = op;
        #1;
        check(tag, alu_result, exp);
    endtask

    // Write one register and check the old value before the edge and the
    // new value after it, through read port 1.
    task automatic write_reg(input logic [4:0] idx, input logic [31:0] data,
                             input logic [31:0] old_val, input logic [31:0] new_val);
        @(negedge clk);
        write_rb  = 1'b1;
        rd_0      = idx;
        writedata = data;
        rs_1      = idx;
        #1;
        check($sformatf("pre_write_x%0d", idx), dut.REGISTER_BANK.readdata_1, old_val);
        @(posedge clk);
        #1;
        check($sformatf("post_write_x%0d", idx), dut.REGISTER_BANK.readdata_1, new_val);
    endtask

    initial begin
        checks_n    = 0;
        fails_n     = 0;
        rst_n       = 1'b1;
        write_rb    = 1'b0;
        rd_0        = 5'd0;
        writedata   = 32'd0;
        rs_1        = 5'd0;
        rs_2        = 5'd0;
        alu_control = 3'b010;
`ifdef DATAPATH_SLT_EN
        exp_slt = 32'd1;
`else
        exp_slt = 32'd0;
`endif

        // reset pulse
        #2 rst_n = 1'b0;
        #1;
        rs_1 = 5'd7;
        rs_2 = 5'd31;
        #1;
        check("reset_rd1", dut.REGISTER_BANK.readdata_1, 32'd0);
        check("reset_rd2", dut.REGISTER_BANK.readdata_2, 32'd0);
        check("reset_alu_add", alu_result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // fill X0..X31 with (i+1)*2; X0 stays zero
        for (int i = 0; i < 32; i++) begin
            write_reg(5'(i), 32'((i + 1) * 2), 32'd0, (i == 0) ? 32'd0 : 32'((i + 1) * 2));
        end

        // hold with write_rb=0
        @(negedge clk);
        write_rb  = 1'b0;
        rd_0      = 5'd10;
        writedata = 32'hDEADBEEF;
        rs_1      = 5'd10;
        @(posedge clk);
        #1;
        check("hold_x10", dut.REGISTER_BANK.readdata_1, 32'd22);

        alu_check("add_4_23",  5'd4,  5'd23, 3'b010, 32'd58);
        alu_check("sub_17_9",  5'd17, 5'd9,  3'b110, 32'd16);
        alu_check("sub_9_17",  5'd9,  5'd17, 3'b110, 32'hFFFFFFF0);
        alu_check("and_1_2",   5'd1,  5'd2,  3'b000, 32'd4);
        alu_check("or_1_2",    5'd1,  5'd2,  3'b001, 32'd6);
        alu_check("op011_1_2", 5'd1,  5'd2,  3'b011, 32'd0);
        alu_check("op100_1_2", 5'd1,  5'd2,  3'b100, 32'd0);
        alu_check("op101_1_2", 5'd1,  5'd2,  3'b101, 32'd0);
        alu_check("slt_1_2",   5'd1,  5'd2,  3'b111, exp_slt);
        alu_check("slt_2_1",   5'd2,  5'd1,  3'b111, 32'd0);
        alu_check("add_x0_5",  5'd0,  5'd5,  3'b010, 32'd12);

        // combinational follow of a register change in the same cycle
        @(negedge clk);
        rs_1        = 5'd3;
        rs_2        = 5'd3;
        alu_control = 3'b010;
        write_rb    = 1'b1;
        rd_0        = 5'd3;
        writedata   = 32'd100;
        #1;
        check("follow_pre", alu_result, 32'd16);
        @(posedge clk);
        #1;
        check("follow_post", alu_result, 32'd200);

        // asynchronous reset between edges with a write pending
        @(negedge clk);
        write_rb  = 1'b1;
        rd_0      = 5'd8;
        writedata = 32'hCAFEF00D;
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 32; i++) begin
            rs_1 = 5'(i);
            rs_2 = 5'(31 - i);
            #0.1;
            check($sformatf("async_rst_x%0d", i), dut.REGISTER_BANK.readdata_1, 32'd0);
        end
        alu_control = 3'b010;
        #0.1;
        check("async_rst_alu", alu_result, 32'd0);
        @(posedge clk);
        #1;
        rs_1 = 5'd8;
        #0.1;
        check("rst_discard_x8", dut.REGISTER_BANK.readdata_1, 32'd0);
        @(negedge clk);
        write_rb = 1'b0;
        #1 rst_n = 1'b1;

        write_reg(5'd5, 32'h12345678, 32'd0, 32'h12345678);
        write_reg(5'd6, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFF);
        write_reg(5'd7, 32'd2,        32'd0, 32'd2);
        @(negedge clk);
        write_rb = 1'b0;
        alu_check("add_wrap_6_7", 5'd6, 5'd7, 3'b010, 32'd1);
        alu_check("sub_wrap_7_6", 5'd7, 5'd6, 3'b110, 32'd3);
        alu_check("slt_neg_6_7",  5'd6, 5'd7, 3'b111, exp_slt);

        $display("End of test - %0d assertions evaluated, %0d failures", checks_n, fails_n);
        $finish;
    end

endmodule
